reg_writeback_queue: RTL and testbench

//  Write-side companion to the architectural register file: gathers results from the ALU
//  and load pipelines and drives the register file's single write port (write_to_rd/rd/rd_value).
//  - Results queue in a small in-order FIFO and retire one per cycle.
//  - Decode-stage operand reads see queued values through an rs1/rs2 bypass lookup.

---
 rtl/reg_writeback_queue.sv | 177 +++++++++++++++++
 tb/tb_reg_writeback_queue.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_queue.sv
`default_nettype none

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

// ============================================================================
// Module      : reg_writeback_queue
// Description : In-order result queue feeding the register file write port.
//               Accepts ALU and load results, retires one entry per cycle,
//               and offers an rs1/rs2 bypass lookup over queued entries.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  // ALU producer
  input  logic                    alu_valid,
  input  logic [4:0]              alu_rd,
  input  logic [`WORD_SIZE-1:0]   alu_value,
  output logic                    alu_ready,
  // Load producer
  input  logic                    load_valid,
  input  logic [4:0]              load_rd,
  input  logic [`WORD_SIZE-1:0]   load_value,
  output logic                    load_ready,
  // Register file write port
  output logic                    write_to_rd,
  output logic [4:0]              rd,
  output logic [`WORD_SIZE-1:0]   rd_value,
  // Decode-stage bypass lookup
  input  logic [4:0]              rs1,
  input  logic [4:0]              rs2,
  output logic                    rs1_hit,
  output logic [`WORD_SIZE-1:0]   rs1_fwd,
  output logic                    rs2_hit,
  output logic [`WORD_SIZE-1:0]   rs2_fwd
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH + 1);

  typedef logic [c_PTR_W-1:0]    ptr_t;
  typedef logic [c_PTR_W:0]      ptrx_t;
  typedef logic [c_CNT_W-1:0]    cnt_t;
  typedef logic [`WORD_SIZE-1:0] word_t;

  typedef struct packed {
    logic  hit;
    word_t fwd;
  } bypass_t;

  localparam ptrx_t c_DEPTH_X = ptrx_t'(DEPTH);
  localparam cnt_t  c_DEPTH_C = cnt_t'(DEPTH);

  // Queue state
  ptr_t  r_head;
  ptr_t  r_tail;
  cnt_t  r_count;
  logic [4:0] r_ent_rd  [DEPTH];
  word_t      r_ent_val [DEPTH];

  // Per-cycle control
  logic    w_pop;
  cnt_t    w_free;
  logic    w_need_load;
  logic    w_need_alu;
  logic    w_enq_load;
  logic    w_enq_alu;
  ptr_t    w_alu_slot;
  ptr_t    w_head_next;
  ptr_t    w_tail_next;
  cnt_t    w_count_next;
  bypass_t w_bp1;
  bypass_t w_bp2;

  // Modulo-DEPTH pointer advance; offset is at most DEPTH-1 so one
  // conditional subtract is enough even for non power-of-two depths.
  function automatic ptr_t f_ptr_add(input ptr_t base, input ptrx_t offs);
    ptrx_t sum;
    sum = {1'b0, base} + offs;
    if (sum >= c_DEPTH_X) begin
      sum = sum - c_DEPTH_X;
    end
    return sum[c_PTR_W-1:0];
  endfunction

  // Walk occupied entries oldest to youngest; the last match is the youngest.
  function automatic bypass_t f_lookup(input logic [4:0] rs);
    bypass_t res;
    ptr_t    idx;
    res.hit = 1'b0;
    res.fwd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = f_ptr_add(r_head, ptrx_t'(i));
      if ((cnt_t'(i) < r_count) && (rs != 5'd0) && (r_ent_rd[idx] == rs)) begin
        res.hit = 1'b1;
        res.fwd = r_ent_val[idx];
      end
    end
    return res;
  endfunction

  // Space accounting: the head always retires this cycle when present,
  // so its slot is credited to the producers. The load has first claim.
  always_comb begin
    w_pop        = (r_count != '0);
    w_free       = c_DEPTH_C - r_count + cnt_t'(w_pop);
    w_need_load  = load_valid && (load_rd != 5'd0);
    w_need_alu   = alu_valid && (alu_rd != 5'd0);
    load_ready   = (w_free >= cnt_t'(1));
    alu_ready    = (w_free >= (cnt_t'(1) + cnt_t'(w_need_load)));
    // x0 results are handshaken but never occupy a slot
    w_enq_load   = load_valid && load_ready && w_need_load;
    w_enq_alu    = alu_valid && alu_ready && w_need_alu;
    w_alu_slot   = w_enq_load ? f_ptr_add(r_tail, ptrx_t'(1)) : r_tail;
    w_head_next  = w_pop ? f_ptr_add(r_head, ptrx_t'(1)) : r_head;
    w_tail_next  = f_ptr_add(r_tail, ptrx_t'(w_enq_load) + ptrx_t'(w_enq_alu));
    w_count_next = r_count - cnt_t'(w_pop) + cnt_t'(w_enq_load) + cnt_t'(w_enq_alu);
  end

  // Pointer and occupancy registers; reset discards all pending entries.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= w_head_next;
      r_tail  <= w_tail_next;
      r_count <= w_count_next;
    end
  end

  // Entry storage; contents are only observed while counted as occupied.
  always_ff @(posedge clock) begin
    if (w_enq_load) begin
      r_ent_rd[r_tail]  <= load_rd;
      r_ent_val[r_tail] <= load_value;
    end
    if (w_enq_alu) begin
      r_ent_rd[w_alu_slot]  <= alu_rd;
      r_ent_val[w_alu_slot] <= alu_value;
    end
  end

  // Register-file write port driven straight from the head entry.
  always_comb begin
    write_to_rd = 1'b0;
    rd          = 5'd0;
    rd_value    = '0;
    if (w_pop) begin
      write_to_rd = 1'b1;
      rd          = r_ent_rd[r_head];
      rd_value    = r_ent_val[r_head];
    end
  end

  // rs1 bypass lookup over queued entries.
  always_comb begin
    w_bp1   = f_lookup(rs1);
    rs1_hit = w_bp1.hit;
    rs1_fwd = w_bp1.fwd;
  end

  // rs2 bypass lookup over queued entries.
  always_comb begin
    w_bp2   = f_lookup(rs2);
    rs2_hit = w_bp2.hit;
    rs2_fwd = w_bp2.fwd;
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_writeback_queue.sv
`default_nettype none

// ============================================================================
// Module      : tb_reg_writeback_queue
// Description : Self-checking bench for reg_writeback_queue. A queue model
//               predicts the write port, readies and bypass every cycle;
//               directed scenarios add hand-computed checkpoints.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_writeback_queue;

  localparam int DEPTH = 4;

  logic        clock      = 1'b0;
  logic        reset_n    = 1'b0;
  logic        alu_valid  = 1'b0;
  logic [4:0]  alu_rd     = 5'd0;
  logic [31:0] alu_value  = 32'd0;
  logic        load_valid = 1'b0;
  logic [4:0]  load_rd    = 5'd0;
  logic [31:0] load_value = 32'd0;
  logic [4:0]  rs1        = 5'd0;
  logic [4:0]  rs2        = 5'd0;
  logic        alu_ready, load_ready, write_to_rd, rs1_hit, rs2_hit;
  logic [4:0]  rd;
  logic [31:0] rd_value, rs1_fwd, rs2_fwd;

  always #5 clock = ~clock;

  reg_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_value(alu_value), .alu_ready(alu_ready),
    .load_valid(load_valid), .load_rd(load_rd), .load_value(load_value), .load_ready(load_ready),
    .write_to_rd(write_to_rd), .rd(rd), .rd_value(rd_value),
    .rs1(rs1), .rs2(rs2),
    .rs1_hit(rs1_hit), .rs1_fwd(rs1_fwd), .rs2_hit(rs2_hit), .rs2_fwd(rs2_fwd)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int wr_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: plain in-order queue ----------------
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] val;
  } ent_t;

  ent_t mq[$];

  function automatic void model_lookup(input logic [4:0] rs, output logic hit, output logic [31:0] fwd);
    hit = 1'b0;
    fwd = 32'd0;
    if (rs != 5'd0) begin
      foreach (mq[i]) begin
        if (mq[i].rd == rs) begin
          hit = 1'b1;
          fwd = mq[i].val;
        end
      end
    end
  endfunction

  // Compare on the falling edge, then advance the model to what the
  // coming rising edge must do with the inputs currently presented.
  always @(negedge clock) begin
    logic        eh;
    logic [31:0] ef;
    int          free;
    bit          nl, tl, ta;
    if (!reset_n) mq.delete();
    chk("write_to_rd", write_to_rd, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("rd", rd, mq[0].rd);
      chk("rd_value", rd_value, mq[0].val);
    end else begin
      chk("rd", rd, 0);
      chk("rd_value", rd_value, 0);
    end
    model_lookup(rs1, eh, ef);
    chk("rs1_hit", rs1_hit, eh);
    chk("rs1_fwd", rs1_fwd, ef);
    model_lookup(rs2, eh, ef);
    chk("rs2_hit", rs2_hit, eh);
    chk("rs2_fwd", rs2_fwd, ef);
    if (reset_n) begin
      free = DEPTH - mq.size() + ((mq.size() > 0) ? 1 : 0);
      nl   = load_valid && (load_rd != 5'd0);
      chk("load_ready", load_ready, free >= 1);
      chk("alu_ready", alu_ready, free >= 1 + int'(nl));
      if (write_to_rd) wr_seen++;
      tl = load_valid && (free >= 1);
      ta = alu_valid && (free >= 1 + int'(nl));
      if (mq.size() > 0) void'(mq.pop_front());
      if (tl && load_rd != 5'd0) mq.push_back('{rd: load_rd, val: load_value});
      if (ta && alu_rd != 5'd0) mq.push_back('{rd: alu_rd, val: alu_value});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
    #1;
  endtask

  task automatic drive(input logic lv, input logic [4:0] lr, input logic [31:0] lval,
                       input logic av, input logic [4:0] ar, input logic [31:0] aval);
    load_valid = lv; load_rd = lr; load_value = lval;
    alu_valid  = av; alu_rd  = ar; alu_value  = aval;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  logic [4:0] t4_lrd [4] = '{5'd1, 5'd2, 5'd3, 5'd4};
  logic [4:0] t4_ard [4] = '{5'd11, 5'd12, 5'd13, 5'd14};

  initial begin
    int li, ai, stall, cyc, w0;
    bit la, aa;

    // 1: reset while three entries are queued
    repeat (2) step();
    reset_n = 1'b1;
    drive(1'b1, 5'd7, 32'h70, 1'b1, 5'd8, 32'h80);
    step();
    drive(1'b1, 5'd9, 32'h90, 1'b1, 5'd10, 32'hA0);
    step();
    idle();
    rs1 = 5'd9;
    at_neg();
    chk("t1_pre_reset_hit", rs1_hit, 1);
    step();
    reset_n = 1'b0;
    at_neg();
    chk("t1_in_reset_write", write_to_rd, 0);
    step();
    reset_n = 1'b1;
    at_neg();
    chk("t1_post_write", write_to_rd, 0);
    chk("t1_post_rs1_hit", rs1_hit, 0);
    step();

    // 2: single ALU result
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    rs1 = 5'd0;
    at_neg();
    chk("t2_alu_ready", alu_ready, 1);
    step();
    idle();
    at_neg();
    chk("t2_write", write_to_rd, 1);
    chk("t2_rd", rd, 5);
    chk("t2_value", rd_value, 32'hDEADBEEF);
    step();
    at_neg();
    chk("t2_write_done", write_to_rd, 0);
    step();

    // 3: load and ALU to the same register in one cycle
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
    rs1 = 5'd3;
    rs2 = 5'd3;
    at_neg();
    chk("t3_not_yet_visible", rs1_hit, 0);
    step();
    idle();
    at_neg();
    chk("t3_first_value", rd_value, 32'h11);
    chk("t3_fwd_both", rs1_fwd, 32'h22);
    step();
    at_neg();
    chk("t3_second_value", rd_value, 32'h22);
    chk("t3_fwd_one", rs1_fwd, 32'h22);
    step();
    at_neg();
    chk("t3_drained_hit", rs1_hit, 0);
    step();

    // 5: x0 result accepted but dropped
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
    rs1 = 5'd0;
    rs2 = 5'd0;
    at_neg();
    chk("t5_alu_ready", alu_ready, 1);
    step();
    idle();
    at_neg();
    chk("t5_no_write", write_to_rd, 0);
    chk("t5_rs1_zero", rs1_hit, 0);
    step();

    // 4: back-to-back producers with contention
    li = 0; ai = 0; stall = 0; cyc = 0;
    w0 = wr_seen;
    rs1 = 5'd12;
    rs2 = 5'd4;
    while ((li < 4 || ai < 4) && cyc < 40) begin
      drive(li < 4, (li < 4) ? t4_lrd[li] : 5'd0, 32'h100 + li,
            ai < 4, (ai < 4) ? t4_ard[ai] : 5'd0, 32'h200 + ai);
      @(negedge clock);
      la = load_valid && load_ready;
      aa = alu_valid && alu_ready;
      if (load_valid && alu_valid && !alu_ready) stall++;
      @(posedge clock);
      #1;
      if (la) li++;
      if (aa) ai++;
      cyc++;
    end
    idle();
    repeat (6) step();
    chk("t4_accepted", li + ai, 8);
    chk("t4_cycles", cyc, 5);
    chk("t4_stalls", stall, 1);
    chk("t4_writes", wr_seen - w0, 8);

    // 6: fill to DEPTH, then a load during the pop cycle
    drive(1'b1, 5'd21, 32'h21, 1'b1, 5'd22, 32'h22);
    step();
    drive(1'b1, 5'd23, 32'h23, 1'b1, 5'd24, 32'h24);
    step();
    drive(1'b1, 5'd25, 32'h25, 1'b1, 5'd26, 32'h26);
    step();
    drive(1'b1, 5'd27, 32'h27, 1'b0, 5'd0, 32'd0);
    at_neg();
    chk("t6_full_head", rd, 23);
    chk("t6_load_ready", load_ready, 1);
    step();
    idle();
    rs1 = 5'd27;
    rs2 = 5'd26;
    w0  = wr_seen;
    at_neg();
    chk("t6_head_after", rd, 24);
    chk("t6_fwd_new", rs1_fwd, 32'h27);
    repeat (7) step();
    chk("t6_drain_writes", wr_seen - w0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
